// File: rtl/updown_pkg.sv
// Shared types for the up/down auto-repeat counter: FSM states and direction codes.
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/repeat_step_gen.sv
// Typematic step request generator: one step on press, one after the hold
// delay, then one per repeat interval for as long as the same direction is held.
module repeat_step_gen
    import updown_pkg::*;
#(
    parameter int DLY_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic [DLY_W-1:0] hold_dly,
    input  logic [DLY_W-1:0] rpt_dly,
    input  logic             clear,
    output logic             step_req,
    output logic             step_dir
);

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   timer_q, timer_d;
    logic               dir_q, dir_d;
    logic               req_s;
    logic               held_same_s;
    logic               hold_due_s;
    logic               rpt_due_s;

    // Exactly one of up/down is a request; both pressed cancels.
    assign req_s       = up ^ down;
    assign held_same_s = req_s && (up == dir_q);
    // Delay inputs are compared live, so lowering one fires immediately.
    assign hold_due_s  = (timer_q >= hold_dly);
    assign rpt_due_s   = (timer_q >= rpt_dly);

    // State, timer and latched direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= {DLY_W{1'b0}};
            dir_q   <= DIR_DOWN;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state, timer and direction logic.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        if (clear) begin
            state_d = IDLE;
            timer_d = {DLY_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_d = FIRST;
                        timer_d = {DLY_W{1'b0}};
                        dir_d   = up;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FIRST: begin
                    if (!held_same_s) begin
                        // Release, both pressed or reversal: restart from IDLE.
                        state_d = IDLE;
                        timer_d = {DLY_W{1'b0}};
                    end else if (hold_due_s) begin
                        state_d = REPEAT;
                        timer_d = {DLY_W{1'b0}};
                    end else begin
                        timer_d = timer_q + DLY_W'(1);
                    end
                end
                REPEAT: begin
                    if (!held_same_s) begin
                        state_d = IDLE;
                        timer_d = {DLY_W{1'b0}};
                    end else if (rpt_due_s) begin
                        timer_d = {DLY_W{1'b0}};
                    end else begin
                        timer_d = timer_q + DLY_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = {DLY_W{1'b0}};
                end
            endcase
        end
    end

    // Step request decode; the top applies it on the same clock edge.
    always_comb begin
        step_req = 1'b0;
        step_dir = dir_q;
        if (clear) begin
            step_req = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        step_req = 1'b1;
                        step_dir = up;
                    end else begin
                        step_req = 1'b0;
                    end
                end
                FIRST: begin
                    if (held_same_s && hold_due_s) begin
                        step_req = 1'b1;
                    end else begin
                        step_req = 1'b0;
                    end
                end
                REPEAT: begin
                    if (held_same_s && rpt_due_s) begin
                        step_req = 1'b1;
                    end else begin
                        step_req = 1'b0;
                    end
                end
                default: begin
                    step_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/updown_repeat_counter.sv
// Bounded up/down counter with typematic auto-repeat, wrap/saturate modes and
// synchronous load. Timing comes from repeat_step_gen; this level owns the value.
module updown_repeat_counter
    import updown_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               DLY_W   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic [DLY_W-1:0] hold_dly,
    input  logic [DLY_W-1:0] rpt_dly,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             wrapped,
    output logic             dir,
    output logic             at_max,
    output logic             at_min
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             step_q;
    logic             wrapped_q;
    logic             dir_q;
    logic             step_req_s;
    logic             step_dir_s;
    logic             wrap_evt_s;
    logic             changed_s;

    repeat_step_gen #(
        .DLY_W (DLY_W)
    ) u_step_gen (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .hold_dly (hold_dly),
        .rpt_dly  (rpt_dly),
        .clear    (load),
        .step_req (step_req_s),
        .step_dir (step_dir_s)
    );

    // Bounded step: compare against the bound before +/-1 so WIDTH never overflows.
    always_comb begin
        count_d    = count_q;
        wrap_evt_s = 1'b0;
        if (step_dir_s == DIR_UP) begin
            if (count_q < max_val) begin
                count_d = count_q + WIDTH'(1);
            end else if (wrap_mode) begin
                count_d    = min_val;
                wrap_evt_s = 1'b1;
            end else begin
                count_d = max_val;
            end
        end else begin
            if (count_q > min_val) begin
                count_d = count_q - WIDTH'(1);
            end else if (wrap_mode) begin
                count_d    = max_val;
                wrap_evt_s = 1'b1;
            end else begin
                count_d = min_val;
            end
        end
    end

    // A saturated step leaves the value alone and must not pulse step.
    assign changed_s = (count_d != count_q);

    // Count value, output pulses and last accepted direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= RST_VAL;
            step_q    <= 1'b0;
            wrapped_q <= 1'b0;
            dir_q     <= DIR_DOWN;
        end else if (load) begin
            count_q   <= load_val;
            step_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (step_req_s) begin
            count_q   <= count_d;
            step_q    <= changed_s;
            wrapped_q <= wrap_evt_s && changed_s;
            dir_q     <= step_dir_s;
        end else begin
            step_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end
    end

    assign count   = count_q;
    assign step    = step_q;
    assign wrapped = wrapped_q;
    assign dir     = dir_q;
    assign at_max  = (count_q >= max_val);
    assign at_min  = (count_q <= min_val);

endmodule

// File: tb/tb_updown_repeat_counter.sv
// Self-checking bench for updown_repeat_counter: directed scenarios followed by
// randomized held-button traffic, all compared against a cycle-level model.
module tb_updown_repeat_counter;

    localparam int WIDTH = 16;
    localparam int DLY_W = 32;
    localparam logic [WIDTH-1:0] RST_VAL = 16'd0;

    logic             clk = 1'b0;
    logic             rst;
    logic             up;
    logic             down;
    logic [DLY_W-1:0] hold_dly;
    logic [DLY_W-1:0] rpt_dly;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic             wrap_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             step;
    logic             wrapped;
    logic             dir;
    logic             at_max;
    logic             at_min;

    int checks = 0;
    int errors = 0;

    // Model: button-hold view (pressed?, which way, cycles since last step, steps so far).
    int m_count;
    bit m_active;
    bit m_pdir;
    int m_elapsed;
    int m_nsteps;
    bit m_step;
    bit m_wrapped;
    bit m_dir;

    updown_repeat_counter #(
        .WIDTH   (WIDTH),
        .DLY_W   (DLY_W),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .hold_dly  (hold_dly),
        .rpt_dly   (rpt_dly),
        .min_val   (min_val),
        .max_val   (max_val),
        .wrap_mode (wrap_mode),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .step      (step),
        .wrapped   (wrapped),
        .dir       (dir),
        .at_max    (at_max),
        .at_min    (at_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of the specification's rules to the model.
    task automatic model_step();
        bit     req;
        bit     fire;
        bit     wr;
        int     nv;
        int     lo;
        int     hi;
        longint thr;
        fire      = 1'b0;
        m_step    = 1'b0;
        m_wrapped = 1'b0;
        if (rst) begin
            m_count  = int'(RST_VAL);
            m_active = 1'b0;
            m_dir    = 1'b0;
        end else if (load) begin
            m_count  = int'(load_val);
            m_active = 1'b0;
        end else begin
            req = up ^ down;
            if (!req) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active  = 1'b1;
                m_pdir    = up;
                m_dir     = up;
                m_elapsed = 0;
                m_nsteps  = 1;
                fire      = 1'b1;
            end else if (up != m_pdir) begin
                m_active = 1'b0;
            end else begin
                m_elapsed++;
                thr = (m_nsteps == 1) ? longint'(hold_dly) : longint'(rpt_dly);
                if (longint'(m_elapsed) > thr) begin
                    fire      = 1'b1;
                    m_elapsed = 0;
                    m_nsteps++;
                end
            end
            if (fire) begin
                lo = int'(min_val);
                hi = int'(max_val);
                wr = 1'b0;
                if (m_pdir) begin
                    if (m_count < hi) nv = m_count + 1;
                    else if (wrap_mode) begin nv = lo; wr = 1'b1; end
                    else nv = hi;
                end else begin
                    if (m_count > lo) nv = m_count - 1;
                    else if (wrap_mode) begin nv = hi; wr = 1'b1; end
                    else nv = lo;
                end
                m_step    = (nv != m_count);
                m_wrapped = wr && m_step;
                m_count   = nv;
            end
        end
    endtask

    // Advance one clock with the current inputs and compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("count",   32'(count),   32'(m_count));
        chk("step",    32'(step),    32'(m_step));
        chk("wrapped", 32'(wrapped), 32'(m_wrapped));
        chk("dir",     32'(dir),     32'(m_dir));
        chk("at_max",  32'(at_max),  32'(m_count >= int'(max_val)));
        chk("at_min",  32'(at_min),  32'(m_count <= int'(min_val)));
    endtask

    initial begin
        int pat;
        int step_hits;
        rst = 1'b1; up = 1'b0; down = 1'b0; load = 1'b0; load_val = 16'd0;
        hold_dly = 32'd3; rpt_dly = 32'd1; min_val = 16'd0; max_val = 16'hFFFF;
        wrap_mode = 1'b0;
        m_count = 0; m_active = 1'b0; m_pdir = 1'b0; m_elapsed = 0; m_nsteps = 0;
        m_dir = 1'b0; m_step = 1'b0; m_wrapped = 1'b0;

        // Reset state
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        rst = 1'b0;

        // Typematic: hold up for 12 cycles, steps at 0,4,6,8,10
        up = 1'b1;
        step_hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step) step_hits++;
        end
        chk("hold_count", 32'(count), 32'd5);
        chk("hold_steps", 32'(step_hits), 32'd5);
        up = 1'b0;
        tick();

        // Wrap at both bounds
        min_val = 16'd2; max_val = 16'd5; wrap_mode = 1'b1;
        load = 1'b1; load_val = 16'd5; tick(); load = 1'b0;
        up = 1'b1; tick();
        chk("wrap_up_count", 32'(count), 32'd2);
        chk("wrap_up_step", 32'(step), 32'd1);
        chk("wrap_up_flag", 32'(wrapped), 32'd1);
        up = 1'b0; tick();
        down = 1'b1; tick();
        chk("wrap_dn_count", 32'(count), 32'd5);
        chk("wrap_dn_flag", 32'(wrapped), 32'd1);
        down = 1'b0; tick();

        // Saturate at max while held
        wrap_mode = 1'b0;
        load = 1'b1; load_val = 16'd5; tick(); load = 1'b0;
        up = 1'b1;
        step_hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) step_hits++;
        end
        chk("sat_count", 32'(count), 32'd5);
        chk("sat_steps", 32'(step_hits), 32'd0);
        chk("sat_at_max", 32'(at_max), 32'd1);
        up = 1'b0; tick();

        // Reversal after a short up hold
        min_val = 16'd0; max_val = 16'd100; hold_dly = 32'd3;
        load = 1'b1; load_val = 16'd50; tick(); load = 1'b0;
        up = 1'b1; tick(); tick();
        up = 1'b0; down = 1'b1;
        tick();
        chk("rev_gap_step", 32'(step), 32'd0);
        tick();
        chk("rev_count", 32'(count), 32'd50);
        chk("rev_dir", 32'(dir), 32'd0);
        down = 1'b0; tick();

        // Both pressed, then load while up held
        load = 1'b1; load_val = 16'd20; tick(); load = 1'b0;
        up = 1'b1; down = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("both_count", 32'(count), 32'd20);
        down = 1'b0; load = 1'b1; load_val = 16'd9;
        tick();
        chk("load_count", 32'(count), 32'd9);
        chk("load_step", 32'(step), 32'd0);
        load = 1'b0;
        tick();
        chk("post_load_count", 32'(count), 32'd10);
        up = 1'b0; tick();

        // Reset in the middle of a repeat run
        hold_dly = 32'd1; rpt_dly = 32'd0; up = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1; tick();
        chk("midrst_count", 32'(count), 32'd0);
        rst = 1'b0; tick();
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_step", 32'(step), 32'd1);
        up = 1'b0; tick();

        // Randomized held-button traffic with live delay and bound changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pat = int'($urandom_range(0, 3));
                up = pat[0];
                down = pat[1];
            end
            load = ($urandom_range(0, 49) == 0);
            load_val = 16'($urandom_range(0, 90));
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) begin
                min_val = 16'($urandom_range(0, 40));
                max_val = min_val + 16'($urandom_range(0, 40));
                wrap_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 29) == 0) begin
                hold_dly = 32'($urandom_range(0, 4));
                rpt_dly = 32'($urandom_range(0, 4));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_repeat_counter.md
Name: updown_repeat_counter

Overview:
- Parametrised up/down counter driven by held push-button level signals.
- Typematic auto-repeat: one immediate step on press, a step after an initial hold delay, then steps at a repeat interval.
- Programmable min/max bounds, wrap or saturate mode, synchronous load.
- Feeds display/value-entry logic on the lab board; successor to the single-direction hold counter.

Parameters:
- WIDTH, 16, counter and bound width.
- DLY_W, 32, width of delay inputs and internal timer.
- RST_VAL, 0, count value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- up  in  1  level request, count up (debounced upstream).
- down  in  1  level request, count down.
- hold_dly  in  DLY_W  extra cycles between first and second step.
- rpt_dly  in  DLY_W  extra cycles between subsequent steps.
- min_val  in  WIDTH  lower bound, inclusive.
- max_val  in  WIDTH  upper bound, inclusive.
- wrap_mode  in  1  1 = wrap at bounds, 0 = saturate.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded by load.
- count  out  WIDTH  current value.
- step  out  1  one-cycle pulse, registered: count changed this cycle.
- wrapped  out  1  one-cycle pulse, registered: this change was a wrap.
- dir  out  1  direction of last accepted request (1 = up), registered.
- at_max  out  1  combinational, count >= max_val.
- at_min  out  1  combinational, count <= min_val.

Behaviour:
- Reset:
  - count = RST_VAL; step = wrapped = dir = 0; state IDLE; timer = 0.
  - Reset mid-hold aborts the repeat; a request still held after rst deasserts counts as a new press.
- Priority: rst > load > up/down.
- load:
  - count <= load_val (accepted unclamped); state IDLE; timer 0; step/wrapped 0.
  - up/down ignored that cycle.
- Request decode:
  - req = up XOR down.
  - up & down both high = no request.
- FSM states: IDLE, FIRST, REPEAT.
  - IDLE: req → step event, dir <= up, timer <= 0, go FIRST. Otherwise stay.
  - FIRST: req held with same dir and timer < hold_dly → timer+1. Timer >= hold_dly → step event, timer <= 0, go REPEAT.
  - REPEAT: same as FIRST, compared against rpt_dly; stays in REPEAT.
  - In FIRST or REPEAT, release, both pressed, or direction reversal → IDLE, timer 0, no step. A reversal therefore steps one cycle later, from IDLE.
- Timing:
  - count, step and wrapped update on the edge where the request is first sampled.
  - Step 1 → step 2 spacing: hold_dly+1 cycles. Later steps: rpt_dly+1 cycles.
  - Delay inputs are sampled live; lowering one below the current timer fires on the next cycle.
- Step arithmetic, up:
  - count < max_val → count+1.
  - Otherwise, wrap → min_val with wrapped=1; saturate → max_val.
- Step arithmetic, down:
  - count > min_val → count-1.
  - Otherwise, wrap → max_val with wrapped=1; saturate → min_val.
  - Both directions: no WIDTH overflow, since the bound comparison happens first.
- step asserts only if the new count differs from the old; saturate-held steps give step=0 while timing continues.
- min_val > max_val: unsupported. No hang is permitted; no result is defined.

Decomposition:
- Package updown_pkg: state enum (IDLE, FIRST, REPEAT), DIR_UP/DIR_DOWN constants.
- Sub-module repeat_step_gen:
  - Contains the FSM plus DLY_W timer.
  - Inputs: up, down, hold_dly, rpt_dly, clear (load).
  - Outputs: step_req, step_dir.
- Top holds count register, bound arithmetic and output pulses.

Test Plan:
- Reset, WIDTH=16: rst 1 cycle → count=0, step=0, wrapped=0. Hold up with hold_dly=3, rpt_dly=1 for 12 cycles → step pulses at cycles 0, 4, 6, 8, 10; count=5.
- min=2, max=5, wrap_mode=1, count=5: up press → count=2, step=1, wrapped=1. Down press at count=2 → count=5, wrapped=1.
- Same bounds, wrap_mode=0, count=5: hold up 10 cycles → count stays 5, step never asserts, at_max=1.
- Hold up 2 cycles, then down (hold_dly=3) → one up step, 1-cycle gap in IDLE, down step; net count unchanged, dir=0.
- up & down high together for 20 cycles → no step, count unchanged. load=1 with load_val=9 while up held → count=9, no step that cycle, up step next cycle → 10.
- rst asserted mid-REPEAT with up still held → count=0; first cycle after rst deasserts gives immediate step, count=1.
